// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Registered RV32I/RV64I base-ISA decode stage sitting between fetch and
//   execute. Instructions arrive on a valid/ready handshake, are decoded
//   combinationally and captured into an output register (OR). A one-entry
//   skid register (SR) absorbs the instruction that was accepted while OR was
//   stalled. A one-cycle bubble is inserted when the instruction in OR reads
//   the destination of a LOAD that left OR on the previous edge.
//
//   Build option: define DECODE_M_EXT_EN to accept the OP / funct7=0000001
//   (MUL/DIV) group as legal R-type instructions.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   flush                    drop everything held (OR, SR, load tracking)
//   in_valid/in_ready        fetch handshake; in_ready is a flop (= !SR valid)
//   in_instr, in_pc          instruction word and its address
//   out_valid/out_ready      execute handshake
//   out_pc                   address of the decoded instruction
//   out_ra1/ra2/wa3          rs1/rs2/rd, zero where the format lacks the field
//   out_imm                  sign-extended immediate (0 for R/MISC_MEM/SYSTEM)
//   out_funct3/out_funct7    raw instr[14:12] / instr[31:25]
//   out_src1_sel             0 = rs1, 1 = PC
//   out_src2_sel             0 = rs2, 1 = imm
//   out_wd3_sel              0 = ALU, 1 = memory
//   out_we3/out_wem          register-file / memory write enables
//   out_branch/jal/jalr      control-transfer class
//   out_illegal              unrecognised encoding; all enables forced 0
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_ra1,
    output logic [4:0]      out_ra2,
    output logic [4:0]      out_wa3,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic            out_src1_sel,
    output logic            out_src2_sel,
    output logic            out_wd3_sel,
    output logic            out_we3,
    output logic            out_wem,
    output logic            out_branch,
    output logic            out_jal,
    output logic            out_jalr,
    output logic            out_illegal
);

`ifdef DECODE_M_EXT_EN
    localparam bit M_EXT_EN = 1'b1;
`else
    localparam bit M_EXT_EN = 1'b0;
`endif

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      ra1;
        logic [4:0]      ra2;
        logic [4:0]      wa3;
        logic [XLEN-1:0] imm;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            src1_sel;
        logic            src2_sel;
        logic            wd3_sel;
        logic            we3;
        logic            wem;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            illegal;
    } dec_t;

    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // ---------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ---------------------------------------------------------------------
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        shift_bad;
    logic        bad;
    dec_t        dec;

    assign opc   = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign rs1   = in_instr[19:15];
    assign rs2   = in_instr[24:20];
    assign rd    = in_instr[11:7];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    // Immediate shifts: shamt is 5 bits on RV32 and 6 bits on RV64, so the
    // bits above it must be 0 (or 010000x for SRAI).
    always_comb begin
        shift_bad = 1'b0;
        if (XLEN == 64) begin
            if (f3 == 3'b001)
                shift_bad = (in_instr[31:26] != 6'b000000);
            else if (f3 == 3'b101)
                shift_bad = (in_instr[31:26] != 6'b000000) &&
                            (in_instr[31:26] != 6'b010000);
        end else begin
            if (f3 == 3'b001)
                shift_bad = (f7 != 7'b0000000);
            else if (f3 == 3'b101)
                shift_bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
        end
    end

    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.funct3 = f3;
        dec.funct7 = f7;
        bad        = 1'b0;
        case (opc)
            OPC_LUI: begin
                dec.wa3 = rd; dec.imm = sx(imm_u); dec.src2_sel = 1'b1; dec.we3 = 1'b1;
            end
            OPC_AUIPC: begin
                dec.wa3 = rd; dec.imm = sx(imm_u); dec.src1_sel = 1'b1;
                dec.src2_sel = 1'b1; dec.we3 = 1'b1;
            end
            OPC_JAL: begin
                dec.wa3 = rd; dec.imm = sx(imm_j); dec.src1_sel = 1'b1;
                dec.src2_sel = 1'b1; dec.we3 = 1'b1; dec.jal = 1'b1;
            end
            OPC_JALR: begin
                dec.ra1 = rs1; dec.wa3 = rd; dec.imm = sx(imm_i);
                dec.src2_sel = 1'b1; dec.we3 = 1'b1; dec.jalr = 1'b1;
            end
            OPC_BRANCH: begin
                bad = (f3 == 3'b010) || (f3 == 3'b011);
                dec.ra1 = rs1; dec.ra2 = rs2; dec.imm = sx(imm_b); dec.branch = 1'b1;
            end
            OPC_LOAD: begin
                dec.ra1 = rs1; dec.wa3 = rd; dec.imm = sx(imm_i);
                dec.src2_sel = 1'b1; dec.wd3_sel = 1'b1; dec.we3 = 1'b1;
            end
            OPC_STORE: begin
                dec.ra1 = rs1; dec.ra2 = rs2; dec.imm = sx(imm_s);
                dec.src2_sel = 1'b1; dec.wem = 1'b1;
            end
            OPC_OP_IMM: begin
                bad = shift_bad;
                dec.ra1 = rs1; dec.wa3 = rd; dec.imm = sx(imm_i);
                dec.src2_sel = 1'b1; dec.we3 = 1'b1;
            end
            OPC_OP: begin
                bad = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
                        (M_EXT_EN && f7 == 7'b0000001));
                dec.ra1 = rs1; dec.ra2 = rs2; dec.wa3 = rd; dec.we3 = 1'b1;
            end
            // FENCE and SYSTEM carry no register or immediate operands here.
            OPC_MISC, OPC_SYSTEM: ;
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.funct3  = f3;
            dec.funct7  = f7;
            dec.illegal = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Output register, skid register and load-use tracking
    // ---------------------------------------------------------------------
    dec_t       or_q, or_d, sr_q, sr_d;
    logic       or_valid_q, or_valid_d;
    logic       sr_valid_q, sr_valid_d;
    logic       in_ready_q, in_ready_d;
    logic       ld_pending_q, ld_pending_d;
    logic [4:0] ld_rd_q, ld_rd_d;
    logic       stall, accept, xfer;

    assign stall = ld_pending_q &&
                   ((or_q.ra1 != 5'd0 && or_q.ra1 == ld_rd_q) ||
                    (or_q.ra2 != 5'd0 && or_q.ra2 == ld_rd_q));
    assign out_valid = or_valid_q && !stall;
    assign in_ready  = in_ready_q;
    // Flush overrides both handshakes at the edge.
    assign accept = in_valid && in_ready_q && !flush;
    assign xfer   = out_valid && out_ready && !flush;

    always_comb begin
        or_d         = or_q;
        or_valid_d   = or_valid_q;
        sr_d         = sr_q;
        sr_valid_d   = sr_valid_q;
        ld_pending_d = 1'b0;
        ld_rd_d      = ld_rd_q;
        if (flush) begin
            or_valid_d = 1'b0;
            sr_valid_d = 1'b0;
        end else if (xfer) begin
            if (or_q.wd3_sel && or_q.wa3 != 5'd0) begin
                ld_pending_d = 1'b1;
                ld_rd_d      = or_q.wa3;
            end
            // accept cannot coincide with a full SR since in_ready is low then
            if (sr_valid_q) begin
                or_d       = sr_q;
                sr_valid_d = 1'b0;
            end else if (accept) begin
                or_d = dec;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!or_valid_q) begin
                or_d       = dec;
                or_valid_d = 1'b1;
            end else begin
                sr_d       = dec;
                sr_valid_d = 1'b1;
            end
        end
        in_ready_d = !sr_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_q         <= '0;
            sr_q         <= '0;
            or_valid_q   <= 1'b0;
            sr_valid_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            ld_pending_q <= 1'b0;
            ld_rd_q      <= 5'd0;
        end else begin
            or_q         <= or_d;
            sr_q         <= sr_d;
            or_valid_q   <= or_valid_d;
            sr_valid_q   <= sr_valid_d;
            in_ready_q   <= in_ready_d;
            ld_pending_q <= ld_pending_d;
            ld_rd_q      <= ld_rd_d;
        end
    end

    assign out_pc       = or_q.pc;
    assign out_ra1      = or_q.ra1;
    assign out_ra2      = or_q.ra2;
    assign out_wa3      = or_q.wa3;
    assign out_imm      = or_q.imm;
    assign out_funct3   = or_q.funct3;
    assign out_funct7   = or_q.funct7;
    assign out_src1_sel = or_q.src1_sel;
    assign out_src2_sel = or_q.src2_sel;
    assign out_wd3_sel  = or_q.wd3_sel;
    assign out_we3      = or_q.we3;
    assign out_wem      = or_q.wem;
    assign out_branch   = or_q.branch;
    assign out_jal      = or_q.jal;
    assign out_jalr     = or_q.jalr;
    assign out_illegal  = or_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus a randomized stream
// checked against a format-table reference decoder and a queue model of the
// two-entry buffering.
module tb_decode_stage;
    localparam int XLEN = 32;
    localparam int PC_W = 32;
    localparam int BW   = PC_W + 15 + XLEN + 10 + 9;

`ifdef DECODE_M_EXT_EN
    localparam bit M_EXT = 1'b1;
`else
    localparam bit M_EXT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [31:0]     in_instr = '0;
    logic [PC_W-1:0] in_pc = '0;
    logic            in_ready, out_valid;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_ra1, out_ra2, out_wa3;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic            out_src1_sel, out_src2_sel, out_wd3_sel, out_we3, out_wem;
    logic            out_branch, out_jal, out_jalr, out_illegal;
    logic [BW-1:0]   act;

    int n_vec = 0;
    int n_err = 0;

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_ra1(out_ra1), .out_ra2(out_ra2), .out_wa3(out_wa3), .out_imm(out_imm),
        .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_src1_sel(out_src1_sel), .out_src2_sel(out_src2_sel),
        .out_wd3_sel(out_wd3_sel), .out_we3(out_we3), .out_wem(out_wem),
        .out_branch(out_branch), .out_jal(out_jal), .out_jalr(out_jalr),
        .out_illegal(out_illegal)
    );

    assign act = {out_pc, out_ra1, out_ra2, out_wa3, out_imm, out_funct3, out_funct7,
                  out_src1_sel, out_src2_sel, out_wd3_sel, out_we3, out_wem,
                  out_branch, out_jal, out_jalr, out_illegal};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference decode: opcode -> instruction format letter, then operand
    // usage and immediate are derived from the format alone.
    function automatic logic [BW-1:0] ref_bundle(input logic [31:0] w, input logic [PC_W-1:0] pc);
        byte         fmt;
        logic        bad, s1pc, wd, wm, br, jl, jr, u1, u2, ud, simm;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] imm;
        f7 = w[31:25]; f3 = w[14:12];
        fmt = "N"; bad = 0; s1pc = 0; wd = 0; wm = 0; br = 0; jl = 0; jr = 0;
        case (w[6:0])
            7'h37: fmt = "U";
            7'h17: begin fmt = "U"; s1pc = 1; end
            7'h6F: begin fmt = "J"; s1pc = 1; jl = 1; end
            7'h67: begin fmt = "I"; jr = 1; end
            7'h63: begin fmt = "B"; br = 1; bad = (f3 == 3'd2) || (f3 == 3'd3); end
            7'h03: begin fmt = "I"; wd = 1; end
            7'h23: begin fmt = "S"; wm = 1; end
            7'h13: begin
                fmt = "I";
                if (f3 == 3'd1) bad = (f7 != 0);
                else if (f3 == 3'd5) bad = !(f7 == 0 || f7 == 7'h20);
            end
            7'h33: begin
                fmt = "R";
                bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (M_EXT && f7 == 1));
            end
            7'h0F, 7'h73: fmt = "N";
            default: bad = 1;
        endcase
        if (bad) return {pc, 15'd0, {XLEN{1'b0}}, f3, f7, 8'd0, 1'b1};
        u1   = (fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B");
        u2   = (fmt == "R" || fmt == "S" || fmt == "B");
        ud   = (fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J");
        simm = (fmt == "I" || fmt == "S" || fmt == "U" || fmt == "J");
        case (fmt)
            "I": imm = 32'($signed(w) >>> 20);
            "S": imm = (32'($signed(w) >>> 20) & ~32'h1F) | 32'(w[11:7]);
            "B": imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            "U": imm = w & 32'hFFFFF000;
            "J": imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: imm = 0;
        endcase
        return {pc, u1 ? w[19:15] : 5'd0, u2 ? w[24:20] : 5'd0, ud ? w[11:7] : 5'd0,
                XLEN'($signed(imm)), f3, f7, s1pc, simm, wd, ud, wm, br, jl, jr, 1'b0};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops [12];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h03, 7'h23,
                7'h13, 7'h33, 7'h0F, 7'h73};
        w = $urandom;
        w[6:0] = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        w[11:7]  = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (act !== '0) begin n_err++; $display("FAIL reset_fields: got %h want 0", act); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        out_ready = 0; in_valid = 1; in_instr = 32'hFFF10093; in_pc = 32'h100;
        tick();
        in_valid = 0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        n_vec++; if ({out_ra1, out_ra2, out_wa3} !== {5'd2, 5'd0, 5'd1}) begin n_err++;
            $display("FAIL addi_regs: got %0d/%0d/%0d want 2/0/1", out_ra1, out_ra2, out_wa3); end
        n_vec++; if (out_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addi_imm: got %h want ffffffff", out_imm); end
        n_vec++; if ({out_src2_sel, out_we3} !== 2'b11) begin n_err++;
            $display("FAIL addi_ctl: got src2=%b we3=%b want 1 1", out_src2_sel, out_we3); end
        n_vec++; if (act !== ref_bundle(32'hFFF10093, 32'h100)) begin n_err++;
            $display("FAIL addi_bundle: got %h want %h", act, ref_bundle(32'hFFF10093, 32'h100)); end
        out_ready = 1;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL addi_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_load_use();
        logic [31:0] use_w [2];
        int          want  [2];
        int          bub;
        use_w = '{32'h00528333, 32'h00738333};
        want  = '{1, 0};
        for (int k = 0; k < 2; k++) begin
            out_ready = 1; in_valid = 1; in_instr = 32'h0000A283; in_pc = 32'h200;
            tick();
            in_instr = use_w[k]; in_pc = 32'h204;
            n_vec++; if (out_valid !== 1'b1 || out_wd3_sel !== 1'b1) begin n_err++;
                $display("FAIL lu_load_out[%0d]: got v=%b wd3=%b want 1 1", k, out_valid, out_wd3_sel); end
            tick();
            in_valid = 0;
            bub = 0;
            while (out_valid !== 1'b1 && bub < 5) begin bub++; tick(); end
            n_vec++; if (bub != want[k]) begin n_err++;
                $display("FAIL lu_bubble[%0d]: got %0d want %0d", k, bub, want[k]); end
            n_vec++; if (out_pc !== 32'h204) begin n_err++;
                $display("FAIL lu_pc[%0d]: got %h want 00000204", k, out_pc); end
            tick();
        end
    endtask

    task automatic test_mext();
        out_ready = 0; in_valid = 1; in_instr = 32'h022081B3; in_pc = 32'h280;
        tick();
        in_valid = 0;
        n_vec++; if ({out_illegal, out_we3} !== {!M_EXT, M_EXT}) begin n_err++;
            $display("FAIL mul_decode: got illegal=%b we3=%b want %b %b", out_illegal, out_we3, !M_EXT, M_EXT); end
        n_vec++; if (out_funct7 !== 7'h01) begin n_err++; $display("FAIL mul_funct7: got %h want 01", out_funct7); end
        out_ready = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [PC_W-1:0] got [$];
        int              idx;
        idx = 0;
        out_ready = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (idx < 4);
            in_instr  = 32'h00100093 + (32'(idx) << 20);
            in_pc     = 32'h300 + 32'(idx) * 4;
            if (cyc == 2) begin
                n_vec++; if (in_ready !== 1'b0 || idx != 2) begin n_err++;
                    $display("FAIL bp_full: got in_ready=%b accepts=%0d want 0 2", in_ready, idx); end
            end
            if (out_valid && out_ready) got.push_back(out_pc);
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 0;
        n_vec++; if (got.size() != 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_vec++; if (got[i] !== 32'h300 + 32'(i) * 4) begin n_err++;
                $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], 32'h300 + 32'(i) * 4); end
        end
    endtask

    task automatic test_flush();
        int seen;
        out_ready = 0; in_valid = 1;
        in_instr = 32'h00100093; in_pc = 32'h400; tick();
        in_instr = 32'h00200093; in_pc = 32'h404; tick();
        in_instr = 32'h00300093; in_pc = 32'h408; flush = 1; tick();
        flush = 0; in_valid = 0;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL flush_state: got v=%b rdy=%b want 0 1", out_valid, in_ready); end
        out_ready = 1; seen = 0;
        for (int i = 0; i < 4; i++) begin if (out_valid) seen++; tick(); end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL flush_leak: got %0d outputs want 0", seen); end
    endtask

    task automatic test_beq_reset();
        out_ready = 0; in_valid = 1; in_instr = 32'hFE208EE3; in_pc = 32'h500;
        tick();
        in_instr = 32'h00100093; in_pc = 32'h504;
        n_vec++; if (out_imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL beq_imm: got %h want fffffffc", out_imm); end
        n_vec++; if ({out_branch, out_we3, out_wem} !== 3'b100) begin n_err++;
            $display("FAIL beq_ctl: got br=%b we3=%b wem=%b want 1 0 0", out_branch, out_we3, out_wem); end
        n_vec++; if ({out_ra1, out_ra2, out_wa3} !== {5'd1, 5'd2, 5'd0}) begin n_err++;
            $display("FAIL beq_regs: got %0d/%0d/%0d want 1/2/0", out_ra1, out_ra2, out_wa3); end
        tick();
        #3 rst_n = 0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL async_reset: got v=%b rdy=%b want 0 1", out_valid, in_ready); end
        n_vec++; if (act !== '0) begin n_err++; $display("FAIL async_reset_fields: got %h want 0", act); end
        #2 rst_n = 1;
        in_valid = 0; out_ready = 1;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_survivor: got %b want 0", out_valid); end
    endtask

    // Model: q holds accepted-but-not-consumed words oldest first (size <= 2);
    // ld_flag/ld_rd remember a LOAD with nonzero rd leaving on the last edge.
    task automatic test_random();
        logic [63:0]   q [$];
        logic          ld_flag, exp_ir, exp_ov, haz, xf, ac;
        logic [4:0]    ld_rd, a1, a2;
        logic [BW-1:0] exp_b;
        logic [63:0]   front;
        logic [31:0]   pc;
        ld_flag = 0; ld_rd = 0; pc = 32'h1000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_instr  = rand_instr();
            in_pc     = pc;
            pc        = pc + 4;
            exp_ir = (q.size() < 2);
            haz = 0;
            if (q.size() > 0) begin
                exp_b = ref_bundle(q[0][31:0], q[0][63:32]);
                a1 = exp_b[BW-PC_W-1 -: 5];
                a2 = exp_b[BW-PC_W-6 -: 5];
                haz = ld_flag && ((a1 != 0 && a1 == ld_rd) || (a2 != 0 && a2 == ld_rd));
                n_vec++; if (act !== exp_b) begin n_err++;
                    $display("FAIL rnd_fields @%0d: got %h want %h", cyc, act, exp_b); end
            end
            exp_ov = (q.size() > 0) && !haz;
            n_vec++; if (in_ready !== exp_ir || out_valid !== exp_ov) begin n_err++;
                $display("FAIL rnd_hs @%0d: got rdy=%b v=%b want %b %b", cyc, in_ready, out_valid, exp_ir, exp_ov); end
            if (flush) begin
                q.delete();
                ld_flag = 0;
            end else begin
                xf = exp_ov && out_ready;
                ac = in_valid && exp_ir;
                ld_flag = 0;
                if (xf) begin
                    front   = q.pop_front();
                    ld_flag = (front[6:0] == 7'h03) && (front[11:7] != 0);
                    ld_rd   = front[11:7];
                end
                if (ac) q.push_back({in_pc, in_instr});
            end
            tick();
        end
        flush = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_mext();
        test_back_to_back();
        test_flush();
        test_beq_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I/RV64I-base instruction decode stage between fetch and execute. It accepts fetched instructions over a valid/ready handshake and decodes them into register addresses, an XLEN-wide immediate, datapath selects and control flags. Results are held in an output register backed by a one-entry skid buffer. It inserts a single-cycle bubble on load-use hazards, supports pipeline flush, and flags illegal encodings.

## Interface
- XLEN, 32: datapath width (32 or 64); immediates sign-extended to XLEN
- PC_W, 32: width of the program-counter field carried with each instruction
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  discard all held instructions (redirect from execute)
- in_valid / in_ready  in / out  1 / 1  fetch-side handshake
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction address
- out_valid / out_ready  out / in  1 / 1  execute-side handshake
- out_pc  out  PC_W  address of the decoded instruction
- out_ra1, out_ra2, out_wa3  out  5 each  rs1/rs2/rd; forced 0 when the format does not use the field
- out_imm  out  XLEN  decoded I/S/B/U/J immediate; 0 for R-type, MISC_MEM and SYSTEM
- out_funct3 / out_funct7  out  3 / 7  raw instr[14:12] / instr[31:25]
- out_src1_sel  out  1  0 = rs1, 1 = PC (AUIPC, JAL)
- out_src2_sel  out  1  0 = rs2, 1 = imm
- out_wd3_sel  out  1  0 = ALU, 1 = memory (LOAD)
- out_we3, out_wem  out  1 each  register-file / memory write enable
- out_branch, out_jal, out_jalr  out  1 each  control-transfer class
- out_illegal  out  1  opcode or funct not recognised; all enables 0

## Operation
- Decode is combinational on the incoming word; results are captured into the output register (OR) or the skid register (SR).
- Immediates: I = sext(instr[31:20]); S = sext({instr[31:25], instr[11:7]}); B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}); U = sext({instr[31:12], 12'b0}); J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- Per-class behaviour:
  - LUI: ra1 = 0, src2 = imm.
  - JALR: ra1 = rs1, src2 = imm.
  - BRANCH: ra1 and ra2 are both used; we3 = 0.
  - STORE: wem = 1, we3 = 0.
  - Writes with rd = 0 still assert we3.
- Illegal:
  - Opcode is not one of the eleven base opcodes.
  - OP with funct7 other than 0000000, or 0100000 for funct3 000/101.
  - OP_IMM shift with bad upper bits.
  - BRANCH funct3 of 010 or 011.
- Buffering:
  - in_ready = !SR_valid, driven directly from a flop.
  - An accepted instruction goes to OR when OR is empty or OR is being consumed this cycle; otherwise it goes to SR.
  - When OR is consumed and SR is valid, SR moves to OR.
- Load-use:
  - ld_pending is set for exactly one cycle after an OR transfer of a LOAD with rd ≠ 0; ld_rd records that rd.
  - During that cycle, out_valid = 0 if OR holds an instruction whose nonzero ra1 or ra2 equals ld_rd.
  - ld_pending self-clears at the next edge, so the bubble lasts exactly one cycle.
- Flush:
  - At the edge, OR_valid, SR_valid and ld_pending are all cleared.
  - An instruction presented on in_valid in the flush cycle is dropped.
  - in_ready is 1 on the following cycle.

## Timing
- Reset: out_valid = 0 and in_ready = 1. OR/SR valid bits and ld_pending are 0. All out_* data fields are 0.
- Latency: one cycle from in_valid & in_ready to out_valid, when OR is empty and there is no hazard.
- Throughput: one instruction per cycle with out_ready held high.
- Transfer occurs on any edge where valid & ready are both 1. out_* fields are stable while out_valid = 1 and out_ready = 0.
- Full condition: OR and SR both valid → in_ready = 0. in_ready returns to 1 the cycle after an OR transfer.
- Simultaneous events:
  - Flush has priority over accept and transfer.
  - Accept and transfer in the same cycle with SR empty keeps SR empty.
- Asynchronous reset mid-stream returns all state to reset values immediately; no instruction survives.

## Configuration
- DECODE_M_EXT_EN defined: OP with funct7 = 0000001 is legal (MUL/DIV group). It is decoded as R-type with we3 = 1 and funct7 passed through.
- DECODE_M_EXT_EN undefined: that encoding is illegal (out_illegal = 1, we3 = 0).

## Test plan
- Reset, then addi x1,x2,-1 (0xFFF10093) → one cycle later: out_valid = 1, ra1 = 2, ra2 = 0, wa3 = 1, imm = 0xFFFFFFFF, src2_sel = 1, we3 = 1.
- lw x5,0(x1) (0x0000A283) followed back-to-back by add x6,x5,x5 (0x00528333), out_ready = 1 → add is delayed by exactly one bubble cycle. Repeating with add x6,x7,x7 gives no bubble.
- mul x3,x1,x2 (0x022081B3) → with DECODE_M_EXT_EN: illegal = 0, we3 = 1. Without it: illegal = 1, we3 = 0.
- Stream 4 instructions with out_ready low for 3 cycles → in_ready drops after 2 accepts. All 4 emerge in order, with no loss or duplication.
- Assert flush with OR and SR full and in_valid high → next cycle out_valid = 0 and in_ready = 1. The flushed instructions never appear.
- beq x1,x2,-4 (0xFE208EE3) → imm = 0xFFFFFFFC, branch = 1, we3 = 0, wem = 0. Then drop rst_n mid-stream → out_valid = 0 immediately.
